// File: rtl/m_alu_cmd_issuer.sv
// m_alu_cmd_issuer: command FIFO plus issue FSM feeding the m_alu accumulator.
// Host commands {op,data} are queued. Each one is issued as a single alu_valid cycle.
// Idle gap cycles are inserted after MUL/DIV.
// DIV-by-zero commands are dropped and raise a sticky error.
//
// state | meaning
// IDLE  | nothing registered for issue; pop decision taken every cycle
// ISSUE | alu_valid=1 for exactly this cycle; pop decision unless a gap must follow
// WAIT  | gap_cnt idle cycles after MUL/DIV; pop decision in the last one
module m_alu_cmd_issuer #(
    parameter int WORD  = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WORD-1:0]          in_data,
    input  logic                     halt,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic                     alu_valid,
    output logic [2:0]               alu_op,
    output logic [WORD-1:0]          alu_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     div0_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [2:0] OP_DIV = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state, next_state;
    logic [2:0]      op_mem   [DEPTH];
    logic [WORD-1:0] data_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [GW-1:0]   gap_cnt;

    logic            push, pop, drop, issue, decide, gap_after;
    logic [2:0]      head_op;
    logic [WORD-1:0] head_data;

    assign head_op    = op_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign fifo_count = count;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  next_state = issue ? S_ISSUE : S_IDLE;
                S_ISSUE: next_state = gap_after ? S_WAIT : (issue ? S_ISSUE : S_IDLE);
                S_WAIT:  if (gap_cnt == GW'(1)) next_state = issue ? S_ISSUE : S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Output/control decode: when a pop is allowed and what it does
    always_comb begin
        gap_after = (GAP > 0) && (alu_op[2:1] == 2'b10);
        decide    = (state == S_IDLE)
                 || (state == S_ISSUE && !gap_after)
                 || (state == S_WAIT && gap_cnt == GW'(1));
        pop       = decide && (count != '0) && !halt && !flush;
        drop      = pop && (head_op == OP_DIV) && (head_data == '0);
        issue     = pop && !drop;
        in_ready  = !reset && !flush && (count < FULL);
        push      = in_valid && in_ready;
        busy      = (count != '0) || (state != S_IDLE);
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= in_op;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Issue registers, gap counter and sticky divide-by-zero flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_valid <= 1'b0;
            alu_op    <= '0;
            alu_data  <= '0;
            gap_cnt   <= '0;
            div0_err  <= 1'b0;
        end else begin
            alu_valid <= issue;
            if (issue) begin
                alu_op   <= head_op;
                alu_data <= head_data;
            end
            if (flush)                                 gap_cnt <= '0;
            else if (state == S_ISSUE && gap_after)    gap_cnt <= GW'(GAP);
            else if (state == S_WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
            if (drop)         div0_err <= 1'b1;
            else if (err_clr) div0_err <= 1'b0;
        end
    end

endmodule
